animated_start_screen: RTL and testbench
========================================

// Module: animated_start_screen
// PURPOSE
//  Parametrised, animated start/title screen renderer for the OLED pixel pipeline. Per-pixel lookup
//  of a yellow sign with label, N coloured wires, travelling current pulse, blinking label; sequences
//  press-to-start debounce, fade-out, one-cycle start_game pulse to the top-level game FSM.
//  Sits between the OLED driver's x/y coordinate outputs and its pixel_data input.
// PARAMETERS
//  WIDTH          96  display columns
//  HEIGHT         64  display rows
//  XW             7   x coordinate width
//  YW             6   y coordinate width
//  N_WIRES        5   wires drawn, 1..5
//  PULSE_LEN      8   pulse length in pixels
//  BLINK_FRAMES   16  frames per label blink phase
//  DEBOUNCE_FRAMES 3  consecutive frame_ticks btn_start must be high
//  FADE_STEPS     6   fade frames, 1..6
// PORTS
//  clk         in   1     system clock
//  reset       in   1     asynchronous, active-high reset
//  x           in   XW    current column from OLED driver
//  y           in   YW    current row from OLED driver
//  frame_tick  in   1     one-cycle pulse, once per frame
//  btn_start   in   1     start button, already synchronised, level
//  rearm       in   1     one-cycle pulse: return from DONE to ATTRACT
//  pixel_data  out  16    RGB565 colour for (x,y), registered
//  start_game  out  1     one-cycle pulse on entry to DONE
//  state_o     out  2     FSM state: 0 ATTRACT, 1 PRESSED, 2 FADE, 3 DONE
// BEHAVIOUR
//  Reset (async): state ATTRACT; pulse_pos, blink_cnt, blink_ph, deb_cnt, fade_step = 0;
//   pixel_data = 0; start_game = 0. Reset mid-PRESSED/FADE/DONE -> same values, nothing pending.
//  Latency: pixel_data = colour(x,y) sampled at the clock edge, valid 1 cycle later.
//  Scene, lowest to highest priority:
//   background 16'h0000; x>=WIDTH or y>=HEIGHT -> 0, regardless of any other rule.
//   sign 16'hFFC2: 6<=x<=WIDTH-10, 12<=y<=HEIGHT-11.
//   wire k (0..N_WIRES-1): band rows y in {HEIGHT-22+4k, HEIGHT-21+4k}, x from 3+6k to WIDTH-1;
//    drop cols x in {3+6k, 4+6k}, y from band to HEIGHT-1.
//    Colours k=0..4: 07E0, FD20, 001F, F800, FC0D. Higher k wins on overlap.
//   label: 5-glyph "START", internal 3x5 font ROM, 4-px pitch, origin (41,27), 16'h0000.
//    Hidden (pixel shows sign colour) while blink_ph=1.
//   pulse: band-row pixels with pulse_pos-PULSE_LEN <= x < pulse_pos -> 16'hFFFF.
//    Signed compare, so no wrap artefact at small pulse_pos.
//  Counters, all advance on frame_tick only:
//   pulse_pos: +1 in ATTRACT, range 0..WIDTH+PULSE_LEN-1, wraps to 0. Frozen in all other states.
//   blink_cnt: counts 0..BLINK_FRAMES-1 in ATTRACT; toggles blink_ph on wrap.
//    blink_ph forced 0 outside ATTRACT.
//  FSM, transitions evaluated on frame_tick except where noted:
//   ATTRACT: btn_start=1 -> PRESSED, deb_cnt=1.
//   PRESSED: btn_start=0 -> ATTRACT, deb_cnt=0.
//    btn_start=1 and deb_cnt=DEBOUNCE_FRAMES-1 -> FADE, fade_step=0; else deb_cnt+1.
//   FADE: fade_step+1 each tick; at fade_step=FADE_STEPS-1 -> DONE. btn_start ignored.
//   DONE: rearm=1 -> ATTRACT on any cycle (not tick-gated); counters cleared.
//    rearm outside DONE is ignored.
//  Fade: applied last, on the scene colour. Each channel R5/G6/B5 is logically right-shifted
//   by fade_step, in FADE only. DONE outputs 0 for all in-range pixels.
//  start_game: 1 exactly on the first clk cycle state_o=3; 0 otherwise; never re-fires until rearm.
//  frame_tick coincident with rearm in DONE: rearm wins; counters do not advance that cycle.
// TESTING
//  1 reset asserted mid-FADE, asynchronous to clk -> immediately pixel_data=0, start_game=0,
//    state_o=0; pulse_pos=0.
//  2 after reset, no ticks: (50,15)->16'hFFC2; (3,60)->16'h07E0; (0,0)->0; (100,10)->0;
//    all valid 1 cycle after x,y.
//  3 10 frame_ticks in ATTRACT (pulse_pos=10): (5,42)->16'hFFFF; (10,42)->16'h07E0;
//    (1,42)->0 (left of wire).
//  4 btn_start high for 2 ticks then low -> state_o 1 then 0.
//    Held 3 ticks -> state_o=2 after the 3rd tick.
//  5 FADE step 1: (50,15)->16'h7BE1. After 6 fade ticks: state_o=3, start_game high 1 cycle,
//    (50,15)->0.
//  6 DONE + rearm pulse -> state_o=0, pulse_pos=0, (50,15)->16'hFFC2.
//    rearm in ATTRACT -> no change.

Source files
------------

// File: rtl/animated_start_screen.sv
// Animated title screen: sign, wires, travelling pulse, blinking label,
// debounced start, fade-out and a one-shot start_game pulse.
module animated_start_screen #(
  parameter int WIDTH           = 96,
  parameter int HEIGHT          = 64,
  parameter int XW              = 7,
  parameter int YW              = 6,
  parameter int N_WIRES         = 5,
  parameter int PULSE_LEN       = 8,
  parameter int BLINK_FRAMES    = 16,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FADE_STEPS      = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic          frame_tick,
  input  logic          btn_start,
  input  logic          rearm,
  output logic [15:0]   pixel_data,
  output logic          start_game,
  output logic [1:0]    state_o
);

  localparam int PW = $clog2(WIDTH + PULSE_LEN);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int FW = $clog2(FADE_STEPS + 1);
  localparam int LBL_X = 41;
  localparam int LBL_Y = 27;

  typedef enum logic [1:0] {
    S_ATTRACT = 2'd0,
    S_PRESSED = 2'd1,
    S_FADE    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pulse_pos_q, pulse_pos_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [FW-1:0] fade_step_q, fade_step_d;
  logic [15:0]   pixel_q, pixel_d;
  logic          start_q, start_d;

  int          xi, yi, pp, lx, ly, top;
  logic [14:0] gl_v;
  logic [15:0] col;

  function automatic logic [15:0] wire_col(input int k);
    case (k)
      0:       return 16'h07E0;
      1:       return 16'hFD20;
      2:       return 16'h001F;
      3:       return 16'hF800;
      default: return 16'hFC0D;
    endcase
  endfunction

  // 3x5 glyphs for "START", row 0 in the top bits, left column MSB
  function automatic logic [14:0] glyph(input int g);
    case (g)
      0:       return 15'b111_100_111_001_111;
      1:       return 15'b111_010_010_010_010;
      2:       return 15'b010_101_111_101_101;
      3:       return 15'b110_101_110_101_101;
      default: return 15'b111_010_010_010_010;
    endcase
  endfunction

  // state and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_ATTRACT;
      pulse_pos_q <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      deb_cnt_q   <= '0;
      fade_step_q <= '0;
      pixel_q     <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_pos_q <= pulse_pos_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      deb_cnt_q   <= deb_cnt_d;
      fade_step_q <= fade_step_d;
      pixel_q     <= pixel_d;
      start_q     <= start_d;
    end
  end

  // sequencing: frame-gated counters, debounce, fade, rearm
  always_comb begin
    state_d     = state_q;
    pulse_pos_d = pulse_pos_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    deb_cnt_d   = deb_cnt_q;
    fade_step_d = fade_step_q;
    if (state_q == S_DONE) begin
      if (rearm) begin
        state_d     = S_ATTRACT;
        pulse_pos_d = '0;
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;
        deb_cnt_d   = '0;
        fade_step_d = '0;
      end
    end else if (frame_tick) begin
      unique case (state_q)
        S_ATTRACT: begin
          if (pulse_pos_q == PW'(WIDTH + PULSE_LEN - 1))
            pulse_pos_d = '0;
          else
            pulse_pos_d = pulse_pos_q + 1'b1;
          if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
          if (btn_start) begin
            state_d   = S_PRESSED;
            deb_cnt_d = DW'(1);
          end
        end
        S_PRESSED: begin
          if (!btn_start) begin
            state_d   = S_ATTRACT;
            deb_cnt_d = '0;
          end else if (deb_cnt_q == DW'(DEBOUNCE_FRAMES - 1)) begin
            state_d     = S_FADE;
            fade_step_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
        S_FADE: begin
          if (fade_step_q == FW'(FADE_STEPS - 1))
            state_d = S_DONE;
          else
            fade_step_d = fade_step_q + 1'b1;
        end
        default: ;
      endcase
    end
    if (state_d != S_ATTRACT) blink_ph_d = 1'b0;
    start_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // per-pixel scene lookup, then fade / blank
  always_comb begin
    xi   = int'(x);
    yi   = int'(y);
    pp   = int'(pulse_pos_q);
    lx   = xi - LBL_X;
    ly   = yi - LBL_Y;
    top  = 0;
    gl_v = '0;
    col  = 16'h0000;
    if (xi >= 6 && xi <= WIDTH - 10 && yi >= 12 && yi <= HEIGHT - 11)
      col = 16'hFFC2;
    for (int k = 0; k < N_WIRES; k++) begin
      top = HEIGHT - 22 + 4 * k;
      if ((yi == top || yi == top + 1) && xi >= 3 + 6 * k)
        col = wire_col(k);
      if ((xi == 3 + 6 * k || xi == 4 + 6 * k) && yi >= top)
        col = wire_col(k);
    end
    if (!blink_ph_q && lx >= 0 && lx < 20 && ly >= 0 && ly < 5
        && (lx % 4) != 3) begin
      gl_v = glyph(lx / 4) >> (14 - 3 * ly - (lx % 4));
      if (gl_v[0]) col = 16'h0000;
    end
    // signed window: nothing lights up left of x=0 at small pulse_pos
    for (int k = 0; k < N_WIRES; k++) begin
      top = HEIGHT - 22 + 4 * k;
      if ((yi == top || yi == top + 1) && xi >= 3 + 6 * k
          && xi + PULSE_LEN >= pp && xi < pp)
        col = 16'hFFFF;
    end
    pixel_d = col;
    if (state_q == S_FADE)
      pixel_d = {col[15:11] >> fade_step_q,
                 col[10:5]  >> fade_step_q,
                 col[4:0]   >> fade_step_q};
    if (state_q == S_DONE || xi >= WIDTH || yi >= HEIGHT)
      pixel_d = 16'h0000;
  end

  assign pixel_data = pixel_q;
  assign start_game = start_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_animated_start_screen.sv
// Bench for animated_start_screen: vector tables, hand sequences and
// random stimulus against a behavioural scene/sequence model.
module tb_animated_start_screen;

  localparam int W  = 96;
  localparam int H  = 64;
  localparam int NW = 5;
  localparam int PL = 8;
  localparam int BF = 16;
  localparam int DF = 3;
  localparam int FS = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  x = '0;
  logic [5:0]  y = '0;
  logic        frame_tick = 1'b0;
  logic        btn_start = 1'b0;
  logic        rearm = 1'b0;
  logic [15:0] pixel_data;
  logic        start_game;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  // model state
  int m_state, m_pulse, m_bcnt, m_ph, m_deb, m_fade, m_sg;

  typedef struct {
    int          px;
    int          py;
    logic [15:0] exp;
  } vec_t;

  vec_t t1[18];
  vec_t t2[6];

  animated_start_screen dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick),
    .btn_start  (btn_start),
    .rearm      (rearm),
    .pixel_data (pixel_data),
    .start_game (start_game),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pulse = 0; m_bcnt = 0;
    m_ph = 0; m_deb = 0; m_fade = 0; m_sg = 0;
  endtask

  function automatic string font_row(input byte ch, input int r);
    string s[5];
    case (ch)
      "S":     s = '{"###", "#..", "###", "..#", "###"};
      "A":     s = '{".#.", "#.#", "###", "#.#", "#.#"};
      "R":     s = '{"##.", "#.#", "##.", "#.#", "#.#"};
      default: s = '{"###", ".#.", ".#.", ".#.", ".#."};
    endcase
    return s[r];
  endfunction

  function automatic int wire_colour(input int k);
    int cols[5] = '{'h07E0, 'hFD20, 'h001F, 'hF800, 'hFC0D};
    return cols[k];
  endfunction

  function automatic logic [15:0] model_pix(input int px, input int py);
    int c, r, g, b, lx, ly, band;
    string word, row;
    if (px >= W || py >= H || m_state == 3) return 16'h0000;
    c = 0;
    if (px >= 6 && px <= W - 10 && py >= 12 && py <= H - 11) c = 'hFFC2;
    for (int k = 0; k < NW; k++) begin
      band = H - 22 + 4 * k;
      if ((py == band || py == band + 1) && px >= 3 + 6 * k)
        c = wire_colour(k);
      if ((px == 3 + 6 * k || px == 4 + 6 * k) && py >= band)
        c = wire_colour(k);
    end
    lx = px - 41;
    ly = py - 27;
    word = "START";
    if (m_ph == 0 && lx >= 0 && lx < 20 && ly >= 0 && ly < 5
        && lx % 4 < 3) begin
      row = font_row(word.getc(lx / 4), ly);
      if (row.getc(lx % 4) == "#") c = 0;
    end
    for (int k = 0; k < NW; k++) begin
      band = H - 22 + 4 * k;
      if ((py == band || py == band + 1) && px >= 3 + 6 * k
          && px >= m_pulse - PL && px < m_pulse)
        c = 'hFFFF;
    end
    if (m_state == 2) begin
      r = ((c >> 11) & 31) / (1 << m_fade);
      g = ((c >> 5) & 63) / (1 << m_fade);
      b = (c & 31) / (1 << m_fade);
      c = r * 2048 + g * 32 + b;
    end
    return 16'(c);
  endfunction

  task automatic model_update(input bit tk, input bit bt, input bit ra);
    m_sg = 0;
    if (m_state == 3) begin
      if (ra) model_reset();
    end else if (tk) begin
      if (m_state == 0) begin
        m_pulse = (m_pulse + 1) % (W + PL);
        m_bcnt++;
        if (m_bcnt == BF) begin
          m_bcnt = 0;
          m_ph = 1 - m_ph;
        end
        if (bt) begin
          m_state = 1;
          m_deb = 1;
        end
      end else if (m_state == 1) begin
        if (!bt) begin
          m_state = 0;
          m_deb = 0;
        end else if (m_deb == DF - 1) begin
          m_state = 2;
          m_fade = 0;
        end else begin
          m_deb++;
        end
      end else begin
        if (m_fade == FS - 1) begin
          m_state = 3;
          m_sg = 1;
        end else begin
          m_fade++;
        end
      end
    end
    if (m_state != 0) m_ph = 0;
  endtask

  task automatic step(input bit tk, input bit bt, input bit ra,
                      input int px, input int py);
    logic [15:0] ep;
    frame_tick = tk;
    btn_start  = bt;
    rearm      = ra;
    x = 7'(px);
    y = 6'(py);
    ep = model_pix(px, py);
    model_update(tk, bt, ra);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    rearm      = 1'b0;
    chk("pix_model", int'(pixel_data), int'(ep));
    chk("state_model", int'(state_o), m_state);
    chk("start_model", int'(start_game), m_sg);
  endtask

  initial begin
    t1[0]  = '{50, 15, 16'hFFC2};
    t1[1]  = '{3, 60, 16'h07E0};
    t1[2]  = '{0, 0, 16'h0000};
    t1[3]  = '{100, 10, 16'h0000};
    t1[4]  = '{41, 27, 16'h0000};
    t1[5]  = '{44, 27, 16'hFFC2};
    t1[6]  = '{42, 28, 16'hFFC2};
    t1[7]  = '{46, 29, 16'h0000};
    t1[8]  = '{50, 42, 16'h07E0};
    t1[9]  = '{9, 46, 16'hFD20};
    t1[10] = '{4, 58, 16'h07E0};
    t1[11] = '{30, 58, 16'hFC0D};
    t1[12] = '{15, 60, 16'h001F};
    t1[13] = '{86, 53, 16'hFFC2};
    t1[14] = '{87, 53, 16'h0000};
    t1[15] = '{5, 12, 16'h0000};
    t1[16] = '{21, 56, 16'hF800};
    t1[17] = '{96, 42, 16'h0000};
    t2[0]  = '{5, 42, 16'hFFFF};
    t2[1]  = '{10, 42, 16'h07E0};
    t2[2]  = '{1, 42, 16'h0000};
    t2[3]  = '{9, 46, 16'hFFFF};
    t2[4]  = '{3, 43, 16'hFFFF};
    t2[5]  = '{9, 47, 16'hFFFF};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix", int'(pixel_data), 0);
    chk("rst_state", int'(state_o), 0);
    chk("rst_start", int'(start_game), 0);
    reset = 1'b0;

    // static scene at pulse_pos 0
    foreach (t1[i]) begin
      step(0, 0, 0, t1[i].px, t1[i].py);
      chk("vec_idle", int'(pixel_data), int'(t1[i].exp));
    end

    // pulse at position 10
    repeat (10) step(1, 0, 0, 0, 0);
    foreach (t2[i]) begin
      step(0, 0, 0, t2[i].px, t2[i].py);
      chk("vec_pulse", int'(pixel_data), int'(t2[i].exp));
    end

    // random attract: pulse wrap, blink, stray rearm ignored
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 1)
        step(1'($urandom_range(0, 1)) & 1'b0, 0,
             1'($urandom_range(0, 7) == 0),
             $urandom_range(0, 127), $urandom_range(0, 63));
      else
        step(1'($urandom_range(0, 1)), 0,
             1'($urandom_range(0, 7) == 0),
             $urandom_range(35, 65), $urandom_range(25, 63));
      if (i % 3 == 0) step(1, 0, 0, 0, 0);
    end
    chk("attract_hold", int'(state_o), 0);

    // short press returns to attract
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("deb_pressed", int'(state_o), 1);
    step(1, 0, 0, 0, 0);
    chk("deb_release", int'(state_o), 0);

    // held press reaches fade
    repeat (3) step(1, 1, 0, 0, 0);
    chk("deb_fade", int'(state_o), 2);
    step(1, 1, 0, 50, 15);
    step(0, 1, 0, 50, 15);
    chk("fade1_pix", int'(pixel_data), 'h7BE1);
    repeat (4) step(1, 0, 0, 50, 15);
    chk("fade_not_done", int'(state_o), 2);
    step(1, 0, 0, 50, 15);
    chk("done_state", int'(state_o), 3);
    chk("done_start", int'(start_game), 1);
    step(0, 0, 0, 50, 15);
    chk("done_start_off", int'(start_game), 0);
    chk("done_pix", int'(pixel_data), 0);
    repeat (3) step(1, 1, 0, 50, 15);
    chk("done_no_refire", int'(start_game), 0);

    // rearm coincident with tick
    step(1, 0, 1, 0, 0);
    chk("rearm_state", int'(state_o), 0);
    step(0, 0, 0, 50, 15);
    chk("rearm_pix", int'(pixel_data), 'hFFC2);
    step(0, 0, 0, 5, 42);
    chk("rearm_pulse0", int'(pixel_data), 'h07E0);

    // random full-sequence traffic
    for (int i = 0; i < 2500; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 19) == 0),
           $urandom_range(0, 100), $urandom_range(0, 63));
    end

    // async reset in the middle of fade
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (10) step(1, 0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 50, 15);
    step(0, 1, 0, 50, 15);
    chk("pre_rst_fade", int'(pixel_data), 'h7BE1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_pix", int'(pixel_data), 0);
    chk("arst_start", int'(start_game), 0);
    chk("arst_state", int'(state_o), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    btn_start = 1'b0;
    step(0, 0, 0, 5, 42);
    chk("arst_pulse0", int'(pixel_data), 'h07E0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
